// File: rtl/screen_fader_pkg.sv
// Shared types and constants for the screen fader.
// Contents:
//   LVL_W / LVL_MAX  brightness level width and full-brightness value
//   PIX_W / CNT_W    4:4:4 colour width and VGA counter width
//   FCNT_W           width of the frames-per-step counter
//   fade_state_t     transition FSM states
package screen_fader_pkg;

  localparam int unsigned LVL_W = 4;
  localparam logic [LVL_W-1:0] LVL_MAX = 4'd15;

  localparam int unsigned PIX_W = 12;
  localparam int unsigned CNT_W = 12;

  localparam int unsigned FCNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CUT_WAIT,
    FADE_OUT,
    SWITCH,
    FADE_IN
  } fade_state_t;

endpackage

// File: rtl/screen_fader_if.sv
// Bundle of the screen fader's stream inputs, control inputs and selected outputs.
// Ports (signals):
//   sel_req, fade_en                       control from the game logic
//   hcount_in .. rgb_in                    per-screen VGA streams, one slot per screen
//   hcount_out .. rgb_out                  selected, scaled, registered stream
//   active_sel, busy                       status
// Modports: slave = the fader, master = whatever drives the streams and watches the output.
interface screen_fader_if #(
  parameter int unsigned N_SCREENS = 4,
  parameter int unsigned SEL_W     = $clog2(N_SCREENS)
);
  import screen_fader_pkg::*;

  logic [SEL_W-1:0]                 sel_req;
  logic                             fade_en;

  logic [N_SCREENS-1:0][CNT_W-1:0] hcount_in;
  logic [N_SCREENS-1:0][CNT_W-1:0] vcount_in;
  logic [N_SCREENS-1:0]             hsync_in;
  logic [N_SCREENS-1:0]             vsync_in;
  logic [N_SCREENS-1:0]             hblnk_in;
  logic [N_SCREENS-1:0]             vblnk_in;
  logic [N_SCREENS-1:0][PIX_W-1:0] rgb_in;

  logic [CNT_W-1:0]                 hcount_out;
  logic [CNT_W-1:0]                 vcount_out;
  logic                             hsync_out;
  logic                             vsync_out;
  logic                             hblnk_out;
  logic                             vblnk_out;
  logic [PIX_W-1:0]                 rgb_out;
  logic [SEL_W-1:0]                 active_sel;
  logic                             busy;

  modport slave (
    input  sel_req, fade_en,
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
    output active_sel, busy
  );

  modport master (
    output sel_req, fade_en,
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
    input  active_sel, busy
  );

endinterface

// File: rtl/screen_fader_rgb_dimmer.sv
// Combinational 4:4:4 brightness scaler.
// Ports:
//   rgb_i    colour in, 4 bits per component
//   level_i  brightness 0..15; 15 passes the colour unchanged, 0 gives black
//   rgb_o    scaled colour, each component (c * (level + 1)) >> 4
module screen_fader_rgb_dimmer
  import screen_fader_pkg::*;
(
  input  logic [PIX_W-1:0] rgb_i,
  input  logic [LVL_W-1:0] level_i,
  output logic [PIX_W-1:0] rgb_o
);

  function automatic logic [3:0] scale4(input logic [3:0] c, input logic [LVL_W-1:0] lvl);
    // 15 * 16 = 240 fits in 8 bits, so no headroom bit is needed
    return 4'(({4'd0, c} * ({4'd0, lvl} + 8'd1)) >> 4);
  endfunction

  always_comb begin
    rgb_o = {scale4(rgb_i[11:8], level_i),
             scale4(rgb_i[7:4],  level_i),
             scale4(rgb_i[3:0],  level_i)};
  end

endmodule

// File: rtl/screen_fader.sv
// N-screen VGA output selector with frame-aligned cut or fade-through-black transitions.
// Ports:
//   clk     pixel clock (40 MHz domain)
//   rst_n   asynchronous active-low reset
//   sf_bus  screen_fader_if.slave: sel_req/fade_en in, per-screen streams in,
//           selected registered stream out (2 clk latency), active_sel and busy out
module screen_fader
  import screen_fader_pkg::*;
#(
  parameter int unsigned N_SCREENS       = 4,
  parameter int unsigned SEL_W           = $clog2(N_SCREENS),
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned DEFAULT_SEL     = 0
) (
  input logic            clk,
  input logic            rst_n,
  screen_fader_if.slave  sf_bus
);

  localparam logic [SEL_W:0]      NScr      = (SEL_W + 1)'(N_SCREENS);
  localparam logic [SEL_W-1:0]    DefSel    = SEL_W'(DEFAULT_SEL);
  localparam logic [FCNT_W-1:0]   FrameLast = FCNT_W'(FRAMES_PER_STEP - 1);

  fade_state_t        state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [SEL_W-1:0]   pending_q, pending_d;
  logic [SEL_W-1:0]   active_sel_q, active_sel_d;

  // Stage 1: selected stream
  logic [CNT_W-1:0]   hcount_s1, vcount_s1;
  logic               hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
  logic [PIX_W-1:0]   rgb_s1;

  // Stage 2: output registers
  logic [CNT_W-1:0]   hcount_s2, vcount_s2;
  logic               hsync_s2, vsync_s2, hblnk_s2, vblnk_s2;
  logic [PIX_W-1:0]   rgb_s2;

  logic [PIX_W-1:0]   rgb_dim;
  logic               fs;
  logic               in_range;
  logic               req_valid;
  logic               step_due;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_s1 <= '0;
      vcount_s1 <= '0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      hblnk_s1  <= 1'b0;
      vblnk_s1  <= 1'b0;
      rgb_s1    <= '0;
    end else begin
      hcount_s1 <= sf_bus.hcount_in[active_sel_q];
      vcount_s1 <= sf_bus.vcount_in[active_sel_q];
      hsync_s1  <= sf_bus.hsync_in[active_sel_q];
      vsync_s1  <= sf_bus.vsync_in[active_sel_q];
      hblnk_s1  <= sf_bus.hblnk_in[active_sel_q];
      vblnk_s1  <= sf_bus.vblnk_in[active_sel_q];
      rgb_s1    <= sf_bus.rgb_in[active_sel_q];
    end
  end

  screen_fader_rgb_dimmer u_dimmer (
    .rgb_i   (rgb_s1),
    .level_i (level_q),
    .rgb_o   (rgb_dim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_s2 <= '0;
      vcount_s2 <= '0;
      hsync_s2  <= 1'b0;
      vsync_s2  <= 1'b0;
      hblnk_s2  <= 1'b0;
      vblnk_s2  <= 1'b0;
      rgb_s2    <= '0;
    end else begin
      hcount_s2 <= hcount_s1;
      vcount_s2 <= vcount_s1;
      hsync_s2  <= hsync_s1;
      vsync_s2  <= vsync_s1;
      hblnk_s2  <= hblnk_s1;
      vblnk_s2  <= vblnk_s1;
      rgb_s2    <= rgb_dim;
    end
  end

  // Rising edge of vertical blanking at stage 1; a switch here lands inside blanking.
  assign fs        = vblnk_s1 & ~vblnk_s2;
  assign in_range  = {1'b0, sf_bus.sel_req} < NScr;
  assign req_valid = in_range && (sf_bus.sel_req != active_sel_q);
  assign step_due  = fs && (frame_cnt_q == FrameLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      level_q      <= LVL_MAX;
      frame_cnt_q  <= '0;
      pending_q    <= DefSel;
      active_sel_q <= DefSel;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      frame_cnt_q  <= frame_cnt_d;
      pending_q    <= pending_d;
      active_sel_q <= active_sel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    frame_cnt_d  = frame_cnt_q;
    pending_d    = pending_q;
    active_sel_d = active_sel_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          pending_d   = sf_bus.sel_req;
          frame_cnt_d = '0;
          state_d     = sf_bus.fade_en ? FADE_OUT : CUT_WAIT;
        end
      end

      CUT_WAIT: begin
        if (in_range) pending_d = sf_bus.sel_req;
        if (fs) begin
          active_sel_d = pending_q;
          state_d      = IDLE;
        end
      end

      FADE_OUT: begin
        if (in_range) pending_d = sf_bus.sel_req;
        if (step_due) begin
          frame_cnt_d = '0;
          if (level_q != '0) level_d = level_q - 1'b1;
          if (level_d == '0) state_d = SWITCH;
        end else if (fs) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end

      SWITCH: begin
        if (in_range) pending_d = sf_bus.sel_req;
        if (fs) begin
          // pending may equal active_sel after a retarget; then this is a no-op
          active_sel_d = pending_q;
          frame_cnt_d  = '0;
          state_d      = FADE_IN;
        end
      end

      FADE_IN: begin
        if (step_due) begin
          frame_cnt_d = '0;
          if (level_q != LVL_MAX) level_d = level_q + 1'b1;
          if (level_d == LVL_MAX) state_d = IDLE;
        end else if (fs) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sf_bus.hcount_out = hcount_s2;
  assign sf_bus.vcount_out = vcount_s2;
  assign sf_bus.hsync_out  = hsync_s2;
  assign sf_bus.vsync_out  = vsync_s2;
  assign sf_bus.hblnk_out  = hblnk_s2;
  assign sf_bus.vblnk_out  = vblnk_s2;
  assign sf_bus.rgb_out    = rgb_s2;
  assign sf_bus.active_sel = active_sel_q;
  assign sf_bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_screen_fader.sv
// Self-checking bench for screen_fader: three screens sharing a tiny VGA timing,
// random pixel data, and a frame-level reference model of the selector/fader.
module tb_screen_fader;

  localparam int N   = 3;
  localparam int F   = 2;
  localparam int DEF = 0;
  localparam int HT  = 16;  // total pixels per line
  localparam int VT  = 6;   // total lines per frame
  localparam int HV  = 12;  // visible pixels per line
  localparam int VV  = 4;   // visible lines per frame

  typedef struct packed {
    logic [11:0]        hc;
    logic [11:0]        vc;
    logic               hs;
    logic               vs;
    logic               hb;
    logic               vb;
    logic [N-1:0][11:0] rgb;
  } pix_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  screen_fader_if #(.N_SCREENS(N)) sf_if ();

  screen_fader #(
    .N_SCREENS       (N),
    .FRAMES_PER_STEP (F),
    .DEFAULT_SEL     (DEF)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sf_bus (sf_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  pix_t cur, p1;
  int   gh = 0, gv = 0;
  int   skip = 0;
  bit   rgb_const = 0;
  logic [11:0] const_col [N] = '{12'hFFF, 12'hF84, 12'h7C3};

  // Reference model: frames elapsed since a request decide level and selection.
  int m_sel = DEF, m_pend = DEF, m_n = 0;
  bit m_active = 0, m_fade = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_level();
    if (!m_active || !m_fade) return 15;
    if (m_n <= 15 * F) return 15 - m_n / F;
    return (m_n - 15 * F - 1) / F;
  endfunction

  function automatic logic [11:0] dim(input logic [11:0] c, input int lvl);
    int r, g, b;
    r = int'(c[11:8]);
    g = int'(c[7:4]);
    b = int'(c[3:0]);
    return {4'((r * (lvl + 1)) / 16), 4'((g * (lvl + 1)) / 16), 4'((b * (lvl + 1)) / 16)};
  endfunction

  task automatic m_try_req();
    int s;
    s = int'(sf_if.sel_req);
    if (!m_active) begin
      if (s < N && s != m_sel) begin
        m_active = 1;
        m_fade   = sf_if.fade_en;
        m_pend   = s;
        m_n      = 0;
      end
    end else if (s < N && (m_fade ? (m_n <= 15 * F) : (m_n == 0))) begin
      m_pend = s;
    end
  endtask

  task automatic m_frame();
    if (m_active) begin
      m_n++;
      if (!m_fade) begin
        m_sel    = m_pend;
        m_active = 0;
      end else begin
        if (m_n == 15 * F + 1) m_sel = m_pend;
        if (m_n == 30 * F + 1) m_active = 0;
      end
    end
    m_try_req();
  endtask

  task automatic drive();
    bit vis;
    vis    = (gh < HV) && (gv < VV);
    cur.hc = 12'(gh);
    cur.vc = 12'(gv);
    cur.hs = (gh >= 13 && gh <= 14);
    cur.vs = (gv == 4);
    cur.hb = (gh >= HV);
    cur.vb = (gv >= VV);
    for (int i = 0; i < N; i++) begin
      cur.rgb[i] = vis ? (rgb_const ? const_col[i] : 12'($urandom)) : 12'h000;
      sf_if.hcount_in[i] = cur.hc;
      sf_if.vcount_in[i] = cur.vc;
      sf_if.hsync_in[i]  = cur.hs;
      sf_if.vsync_in[i]  = cur.vs;
      sf_if.hblnk_in[i]  = cur.hb;
      sf_if.vblnk_in[i]  = cur.vb;
      sf_if.rgb_in[i]    = cur.rgb[i];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tim"}, {sf_if.hcount_out, sf_if.vcount_out, sf_if.hsync_out,
                             sf_if.vsync_out, sf_if.hblnk_out, sf_if.vblnk_out}, 32'd0);
    check_eq({tag, "_rgb"}, sf_if.rgb_out, 32'd0);
    check_eq({tag, "_sel"}, sf_if.active_sel, DEF);
    check_eq({tag, "_busy"}, sf_if.busy, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check_reset_outputs("rst");
    end else if (skip > 0) begin
      skip--;
    end else begin
      check_eq("timing", {sf_if.hcount_out, sf_if.vcount_out, sf_if.hsync_out,
                          sf_if.vsync_out, sf_if.hblnk_out, sf_if.vblnk_out},
               {p1.hc, p1.vc, p1.hs, p1.vs, p1.hb, p1.vb});
      check_eq("rgb", sf_if.rgb_out, dim(p1.rgb[m_sel], m_level()));
      if (!p1.hb && !p1.vb) begin
        check_eq("active_sel", sf_if.active_sel, m_sel);
        check_eq("busy", sf_if.busy, m_active);
      end
      if (p1.vc == 12'(VV) && p1.hc == 12'd0) m_frame();
    end
    p1 = cur;
    gh++;
    if (gh == HT) begin
      gh = 0;
      gv++;
      if (gv == VT) gv = 0;
    end
    drive();
  endtask

  task automatic run_frames(input int n);
    repeat (n * HT * VT) step();
  endtask

  task automatic goto_pix(input int v, input int h);
    int k;
    k = 0;
    while (!(gv == v && gh == h) && k < HT * VT + 2) begin
      step();
      k++;
    end
  endtask

  task automatic request(input int s, input bit fe);
    goto_pix(1, 5);
    sf_if.sel_req = 2'(s);
    sf_if.fade_en = fe;
    m_try_req();
  endtask

  task automatic run_until_idle(input string tag, input int max_frames);
    int k;
    k = 0;
    while (m_active && k < max_frames) begin
      run_frames(1);
      k++;
    end
    goto_pix(2, 3);
    check_eq(tag, sf_if.busy, 32'd0);
  endtask

  initial begin
    int busy_frames;
    bit done;
    sf_if.sel_req = '0;
    sf_if.fade_en = 1'b0;
    drive();
    p1 = cur;

    // Reset held mid-line, then released in the visible area
    repeat (7) step();
    goto_pix(1, 2);
    rst_n = 1'b1;
    skip  = 1;
    m_try_req();
    run_frames(3);

    // Cut 0 -> 2
    request(2, 1'b0);
    step();
    check_eq("cut_busy", sf_if.busy, 32'd1);
    run_until_idle("cut_idle", 4);
    run_frames(2);

    // Fade 2 -> 1 with constant colours; fade_en dropped mid-way has no effect
    rgb_const = 1;
    request(1, 1'b1);
    busy_frames = 0;
    done = 0;
    while (!done && busy_frames < 100) begin
      goto_pix(2, 3);
      if (sf_if.busy) begin
        busy_frames++;
        if (busy_frames == 3) sf_if.fade_en = 1'b0;
        step();
      end else begin
        done = 1;
      end
    end
    check_eq("fade_len", busy_frames, 30 * F + 1);
    rgb_const = 0;
    run_frames(2);

    // Retarget during fade-out (2 -> 0), ignored request in fade-in, then new fade
    request(2, 1'b1);
    run_frames(5);
    sf_if.sel_req = 2'd0;
    m_try_req();
    run_frames(15 * F + 3);
    sf_if.sel_req = 2'd2;
    m_try_req();
    run_until_idle("retarget_idle", 200);
    check_eq("retarget_sel", sf_if.active_sel, 32'd2);

    // Retarget back to the current screen: switch is a no-op
    request(0, 1'b1);
    run_frames(3);
    sf_if.sel_req = 2'd2;
    m_try_req();
    run_until_idle("noop_idle", 100);
    check_eq("noop_sel", sf_if.active_sel, 32'd2);

    // Out-of-range request
    request(3, 1'b1);
    run_frames(3);
    check_eq("oor_busy", sf_if.busy, 32'd0);
    check_eq("oor_sel", sf_if.active_sel, 32'd2);

    // Random requests
    for (int i = 0; i < 3; i++) begin
      request(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      run_frames(int'($urandom_range(1, 4)));
      run_until_idle("rand_idle", 200);
    end

    // Reset in the middle of a fade, at level 7
    request((int'(sf_if.active_sel) + 1) % N, 1'b1);
    for (int k = 0; k < 60 && m_level() != 7; k++) run_frames(1);
    goto_pix(1, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sf_if.sel_req = 2'(DEF);
    m_sel    = DEF;
    m_pend   = DEF;
    m_active = 0;
    m_n      = 0;
    repeat (20) step();
    goto_pix(1, 2);
    rst_n = 1'b1;
    skip  = 1;
    m_try_req();
    run_frames(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
